mult_hilo_ctrl: RTL and testbench

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

---
 rtl/mult_pkg.sv | 14 +
 rtl/hilo_reg.sv | 58 +++++
 rtl/mult_hilo_ctrl.sv | 113 +++++++++++
 tb/tb_mult_hilo_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the HI/LO multiply controller.
// The default latency matches the downstream multiplier pipeline depth.
package mult_pkg;

    localparam int MULT_LATENCY_DEF = 4;
    localparam int HILO_W           = 32;
    localparam int PROD_W           = 2 * HILO_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mult_state_e;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair: takes a full 64-bit product or independent move-to writes,
// and presents a combinational read port with HI taking priority over LO.
module hilo_reg
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [PROD_W-1:0] cap_val,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [HILO_W-1:0] wdata,
    input  logic              rd_hi,
    input  logic              rd_lo,
    output logic [HILO_W-1:0] rdata
);

    logic [HILO_W-1:0] hi_q, hi_d;
    logic [HILO_W-1:0] lo_q, lo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // A capture and a move-to never coincide (move-to is refused while busy),
    // but the capture is given priority so the product always lands intact.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_en) begin
            hi_d = cap_val[PROD_W-1:HILO_W];
            lo_d = cap_val[HILO_W-1:0];
        end else begin
            if (wr_hi) begin
                hi_d = wdata;
            end
            if (wr_lo) begin
                lo_d = wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_hi) begin
            rdata = hi_q;
        end else if (rd_lo) begin
            rdata = lo_q;
        end
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequences a fixed-latency external signed multiplier and owns the HI/LO
// result registers; every request arriving while a multiply is in flight is stalled.
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HILO_W-1:0] op_a,
    input  logic [HILO_W-1:0] op_b,
    output logic [HILO_W-1:0] mul_a,
    output logic [HILO_W-1:0] mul_b,
    input  logic [PROD_W-1:0] mul_product,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [HILO_W-1:0] wdata,
    input  logic              rd_hi,
    input  logic              rd_lo,
    output logic [HILO_W-1:0] rdata,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output mult_state_e       dbg_state
);

    // Handshake: a request is taken on any rising edge where stall is low;
    // while stall is high the requester must hold it and nothing changes.
    localparam int CNT_W = $clog2(MULT_LATENCY + 1);

    mult_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HILO_W-1:0] op_a_q, op_a_d;
    logic [HILO_W-1:0] op_b_q, op_b_d;
    logic              done_q, done_d;
    logic              capture;
    logic              wr_hi_en;
    logic              wr_lo_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            done_q  <= done_d;
        end
    end

    // The counter holds the edges still to go; the product is taken on the
    // edge that would bring it from 1 to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        done_d  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(MULT_LATENCY);
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    capture = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_BUSY);
        stall     = busy & (start | mthi | mtlo | rd_hi | rd_lo);
        wr_hi_en  = mthi & ~busy;
        wr_lo_en  = mtlo & ~busy;
        done      = done_q;
        mul_a     = op_a_q;
        mul_b     = op_b_q;
        dbg_state = state_q;
    end

    hilo_reg u_hilo_reg (
        .clk     (clk),
        .reset   (reset),
        .cap_en  (capture),
        .cap_val (mul_product),
        .wr_hi   (wr_hi_en),
        .wr_lo   (wr_lo_en),
        .wdata   (wdata),
        .rd_hi   (rd_hi),
        .rd_lo   (rd_lo),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: pipelined multiplier stand-in, edge-indexed reference
// model with a per-cycle compare process, and directed scenarios with literal results.
module tb_mult_hilo_ctrl;
    import mult_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_product;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_hi = 1'b0;
    logic        rd_lo = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;
    logic        done;
    mult_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(.MULT_LATENCY(L)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .rd_hi       (rd_hi),
        .rd_lo       (rd_lo),
        .rdata       (rdata),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Multiplier stand-in: product appears L-1 edges after operands change,
    // so it is valid on exactly the L-th edge after the operands are presented.
    logic signed [63:0] pipe [L-1];
    always @(posedge clk) begin
        pipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_product = pipe[L-2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a multiply accepted at edge e completes at edge e+L.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [63:0] m_prod = '0;
    logic        m_pending = 1'b0, m_done = 1'b0;
    int          m_edge = 0, m_cap_edge = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_a <= '0; m_b <= '0;
            m_pending <= 1'b0; m_done <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            m_done <= 1'b0;
            if (m_pending) begin
                if (m_edge + 1 == m_cap_edge) begin
                    m_hi <= m_prod[63:32];
                    m_lo <= m_prod[31:0];
                    m_pending <= 1'b0;
                    m_done <= 1'b1;
                end
            end else begin
                if (start) begin
                    m_a <= op_a;
                    m_b <= op_b;
                    m_prod <= longint'($signed(op_a)) * longint'($signed(op_b));
                    m_cap_edge <= m_edge + 1 + L;
                    m_pending <= 1'b1;
                end
                if (mthi) m_hi <= wdata;
                if (mtlo) m_lo <= wdata;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_stall;
        logic [31:0] e_rdata;
        e_stall = m_pending & (start | mthi | mtlo | rd_hi | rd_lo);
        e_rdata = rd_hi ? m_hi : (rd_lo ? m_lo : 32'h0);
        chk("busy", busy, m_pending);
        chk("stall", stall, e_stall);
        chk("done", done, m_done);
        chk("rdata", rdata, e_rdata);
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
        chk("dbg_state", dbg_state == ST_BUSY, m_pending);
        if (done) n_done++;
    end

    task automatic clear_inputs();
        start = 0; mthi = 0; mtlo = 0; rd_hi = 0; rd_lo = 0;
    endtask

    task automatic wait_done(input string name);
        int waited = 0;
        while (!done && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({name, " done_seen"}, done, 1'b1);
        chk({name, " latency"}, waited, L);
    endtask

    // Called at posedge+1 of an idle cycle; reads both halves in the done cycle.
    task automatic do_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 0;
        wait_done(name);
        rd_lo = 1; #1;
        chk({name, " lo"}, rdata, exp_lo);
        rd_hi = 1; #1;
        chk({name, " hi"}, rdata, exp_hi);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst mul_a", mul_a, 32'h0);
        rd_hi = 1; #1;
        chk("rst hi", rdata, 32'h0);
        rd_hi = 0; rd_lo = 1; #1;
        chk("rst lo", rdata, 32'h0);
        rd_lo = 0;
        reset = 0;

        // First start issued in the cycle reset deasserts.
        do_mult("3x4", 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
        do_mult("neg1x1", 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mult("min_sq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Requests during busy are stalled; the held start goes in the done cycle.
        begin
            int w = 0;
            start = 1; op_a = 32'd5; op_b = 32'd6;
            @(posedge clk); #1;
            start = 0; rd_lo = 1; #1;
            chk("busy rd stall", stall, 1'b1);
            @(posedge clk); #1;
            rd_lo = 0; start = 1; op_a = 32'd7; op_b = 32'd8; #1;
            while (stall && w < 20) begin
                @(posedge clk); #2;
                w++;
            end
            chk("held start in done cycle", done, 1'b1);
            chk("held start unstalled", stall, 1'b0);
            rd_lo = 1; #1;
            chk("read in done cycle", rdata, 32'd30);
            @(posedge clk); #1;
            clear_inputs();
            wait_done("7x8");
            rd_lo = 1; #1;
            chk("7x8 lo", rdata, 32'd56);
            rd_hi = 1; #1;
            chk("7x8 hi", rdata, 32'd0);
            @(posedge clk); #1;
            clear_inputs();
        end

        mthi = 1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi = 0; rd_hi = 1; #1;
        chk("mthi readback", rdata, 32'h1234_5678);
        chk("mthi rd stall", stall, 1'b0);
        rd_hi = 0;

        mthi = 1; mtlo = 1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mthi = 0; mtlo = 0; rd_lo = 1; #1;
        chk("mthilo lo", rdata, 32'h0BAD_F00D);
        rd_hi = 1; #1;
        chk("mthilo hi", rdata, 32'h0BAD_F00D);
        clear_inputs();

        // Move-to alongside start: the product overwrites it later.
        start = 1; op_a = 32'hFFFF_FFF9; op_b = 32'd3;
        mthi = 1; mtlo = 1; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        clear_inputs();
        wait_done("m7x3");
        rd_lo = 1; #1;
        chk("m7x3 lo", rdata, 32'hFFFF_FFEB);
        rd_hi = 1; #1;
        chk("m7x3 hi", rdata, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        clear_inputs();

        // Reset two edges into a multiply aborts it.
        start = 1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1; #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort mul_a", mul_a, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        repeat (L + 2) @(posedge clk);
        #1;
        rd_hi = 1; #1;
        chk("abort hi", rdata, 32'h0);
        rd_hi = 0; rd_lo = 1; #1;
        chk("abort lo", rdata, 32'h0);
        rd_lo = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("done pulse count", n_done, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
